// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int WORD_BYTES       = 4;
  localparam int BYTE_OFFSET_BITS = 2;

  // Replace the byte lanes of old_word selected by be with those of new_word.
  function automatic logic [31:0] merge_bytes(input logic [31:0]           old_word,
                                              input logic [31:0]           new_word,
                                              input logic [WORD_BYTES-1:0] be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_sram_1rw.sv
// DEPTH x 32 single-port array with per-byte write enables and a registered read.
module dmem_sram_1rw
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [WORD_BYTES-1:0] wbe,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: the array and its read register carry no reset so the block can map
  // onto a RAM macro; only the control path needs a defined reset state.
  always_ff @(posedge clk) begin
    if (en) begin
      if (|wbe) mem[addr] <= merge_bytes(mem[addr], wdata, wbe);
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request in flight, fixed wait states.
// Optional address checking is enabled by defining DMEM_RESPONDER_ERR_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  req,
  input  logic                  we,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [WORD_BYTES-1:0] be,
  output logic                  busy,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  err
);

  localparam int         IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  state_t state, next_state;
  logic [3:0] cnt;

  logic                  we_q, err_q;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [WORD_BYTES-1:0] be_q;

  logic                  accept, enter_resp, sram_en;
  logic                  cur_we, cur_err;
  logic [31:0]           cur_addr;
  logic [DATA_WIDTH-1:0] cur_wdata, sram_rdata;
  logic [WORD_BYTES-1:0] cur_be;

  assign accept = (state == IDLE) && req;

  // With zero wait states the array access happens on the accept edge itself,
  // so the request fields come straight from the inputs while idle.
  assign cur_we    = (state == IDLE) ? we         : we_q;
  assign cur_addr  = (state == IDLE) ? address    : addr_q;
  assign cur_wdata = (state == IDLE) ? write_data : wdata_q;
  assign cur_be    = (state == IDLE) ? be         : be_q;

`ifdef DMEM_RESPONDER_ERR_CHECK_EN
  assign cur_err = (cur_addr[BYTE_OFFSET_BITS-1:0] != '0) ||
                   (cur_addr[31:IDX_W+BYTE_OFFSET_BITS] != '0);
`else
  assign cur_err = 1'b0;
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, cur_addr[31:IDX_W+BYTE_OFFSET_BITS],
                              cur_addr[BYTE_OFFSET_BITS-1:0]};
`endif

  // NOTE: every signal driven in this block gets a default before the case,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    busy       = 1'b1;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (req) next_state = (WS == 4'd0) ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt == 4'd1) next_state = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (accept)             cnt <= WS;
      else if (state == WAIT) cnt <= cnt - 4'd1;
    end
  end

  // Request capture is pure datapath; its contents only matter after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= we;
      addr_q  <= address;
      wdata_q <= write_data;
      be_q    <= be;
      err_q   <= cur_err;
    end
  end

  // Gate with nrst so a reset on the edge that would enter RESP commits nothing.
  assign enter_resp = (state != RESP) && (next_state == RESP);
  assign sram_en    = nrst && enter_resp && !cur_err;

  dmem_sram_1rw #(
    .DEPTH  (DEPTH),
    .ADDR_W (IDX_W)
  ) u_sram (
    .clk   (clk),
    .en    (sram_en),
    .addr  (cur_addr[IDX_W+BYTE_OFFSET_BITS-1:BYTE_OFFSET_BITS]),
    .wbe   (cur_we ? cur_be : '0),
    .wdata (cur_wdata),
    .rdata (sram_rdata)
  );

  assign read_data = (resp_valid && !we_q && !err_q) ? sram_rdata : '0;
  assign err       = resp_valid && err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with 2 wait states, one with 0.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        req = 1'b0, req0 = 1'b0;
  logic        we = 1'b0;
  logic [31:0] address = '0, write_data = '0;
  logic [3:0]  be = '0;

  logic        busy, resp_valid, err;
  logic [31:0] read_data;
  logic        busy0, resp_valid0, err0;
  logic [31:0] read_data0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(256), .WAIT_STATES(2), .DATA_WIDTH(32)) dut (
    .clk(clk), .nrst(nrst), .req(req), .we(we), .address(address),
    .write_data(write_data), .be(be), .busy(busy), .resp_valid(resp_valid),
    .read_data(read_data), .err(err)
  );

  dmem_responder #(.DEPTH(256), .WAIT_STATES(0), .DATA_WIDTH(32)) dut0 (
    .clk(clk), .nrst(nrst), .req(req0), .we(we), .address(address),
    .write_data(write_data), .be(be), .busy(busy0), .resp_valid(resp_valid0),
    .read_data(read_data0), .err(err0)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$], sb0[$];
  exp_t got_e, got_e0;
  int   cyc = 0;
  int   n_vec = 0, n_miss = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en && resp_valid === 1'b1) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL resp_unexpected ws2: cycle %0d rdata=%h, no response expected", cyc, read_data);
      end else begin
        got_e = sb.pop_front();
        if (read_data !== got_e.rdata || err !== got_e.err || cyc != got_e.due) begin
          n_miss++;
          $display("FAIL resp ws2: got rdata=%h err=%b cycle=%0d, want rdata=%h err=%b cycle=%0d",
                   read_data, err, cyc, got_e.rdata, got_e.err, got_e.due);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && resp_valid0 === 1'b1) begin
      n_vec++;
      if (sb0.size() == 0) begin
        n_miss++;
        $display("FAIL resp_unexpected ws0: cycle %0d rdata=%h, no response expected", cyc, read_data0);
      end else begin
        got_e0 = sb0.pop_front();
        if (read_data0 !== got_e0.rdata || err0 !== got_e0.err || cyc != got_e0.due) begin
          n_miss++;
          $display("FAIL resp ws0: got rdata=%h err=%b cycle=%0d, want rdata=%h err=%b cycle=%0d",
                   read_data0, err0, cyc, got_e0.rdata, got_e0.err, got_e0.due);
        end
      end
    end
  end

  function automatic logic sel_busy(input bit sel);
    return sel ? busy0 : busy;
  endfunction

  // Called at a falling edge; returns at the falling edge where busy is low again.
  task automatic do_req(input bit sel, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int   ws;
    int   acc;
    int   t;
    exp_t x;
    ws = sel ? 0 : 2;
    t  = 0;
    while (sel_busy(sel) !== 1'b0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_vec++;
      n_miss++;
      $display("FAIL accept_timeout sel=%0d: busy=%b after 50 cycles, want 0", sel, sel_busy(sel));
      return;
    end
    we = w; address = a; write_data = d; be = b;
    if (sel) req0 = 1'b1; else req = 1'b1;
    acc     = cyc;
    x.rdata = exp_rdata;
    x.err   = exp_err;
    x.due   = acc + 1 + ws;
    if (sel) sb0.push_back(x); else sb.push_back(x);
    @(negedge clk);
    req = 1'b0; req0 = 1'b0;
    t = 0;
    while (sel_busy(sel) !== 1'b0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (cyc - acc != 2 + ws) begin
      n_miss++;
      $display("FAIL busy_release sel=%0d addr=%h: busy low after %0d cycles, want %0d",
               sel, a, cyc - acc, 2 + ws);
    end
  endtask

  task automatic test_reset();
    int seen;
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec += 4;
    if (busy !== 1'b0)         begin n_miss++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (resp_valid !== 1'b0)   begin n_miss++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    if (read_data !== 32'h0)   begin n_miss++; $display("FAIL reset_read_data: got %h want 0", read_data); end
    if (err !== 1'b0)          begin n_miss++; $display("FAIL reset_err: got %b want 0", err); end
    nrst   = 1'b1;
    mon_en = 1'b1;
    seen   = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || resp_valid0 !== 1'b0 || busy !== 1'b0) seen++;
    end
    n_vec++;
    if (seen != 0) begin n_miss++; $display("FAIL idle_quiet: %0d active cycles, want 0", seen); end
  endtask

  task automatic test_store_load();
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    do_req(0, 1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0);
  endtask

  task automatic test_byte_lanes();
    do_req(0, 1'b1, 32'h20, 32'h11223344, 4'hF,    32'h0, 1'b0);
    do_req(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
    do_req(0, 1'b0, 32'h20, 32'h0,        4'h0,    32'h11BB33DD, 1'b0);
    do_req(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0,    32'h0, 1'b0);
    do_req(0, 1'b0, 32'h20, 32'h0,        4'hF,    32'h11BB33DD, 1'b0);
  endtask

  task automatic test_zero_wait();
    exp_t x;
    do_req(1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
    we = 1'b0; address = 32'h40; be = 4'h0;
    req0 = 1'b1;
    // req stays high: accepts only every other edge, the RESP cycle is skipped.
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if (busy0 !== ((i % 2) == 1)) begin
        n_miss++;
        $display("FAIL zero_wait_busy step %0d: got %b want %b", i, busy0, (i % 2) == 1);
      end
      if ((i % 2) == 0) begin
        x.rdata = 32'hCAFEF00D; x.err = 1'b0; x.due = cyc + 1;
        sb0.push_back(x);
      end
      @(negedge clk);
    end
    req0 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen;
    do_req(0, 1'b1, 32'h30, 32'h0, 4'hF, 32'h0, 1'b0);
    we = 1'b1; address = 32'h30; write_data = 32'hFFFFFFFF; be = 4'hF;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin n_miss++; $display("FAIL mid_accepted: busy=%b want 1", busy); end
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    seen = 0;
    repeat (6) begin
      if (busy !== 1'b0 || resp_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    n_vec++;
    if (seen != 0) begin n_miss++; $display("FAIL mid_discard: %0d active cycles, want 0", seen); end
    do_req(0, 1'b0, 32'h30, 32'h0, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic test_err();
    do_req(0, 1'b1, 32'h0, 32'h12345678, 4'hF, 32'h0, 1'b0);
`ifdef DMEM_RESPONDER_ERR_CHECK_EN
    do_req(0, 1'b0, 32'h402, 32'h0,        4'h0, 32'h0, 1'b1);
    do_req(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    do_req(0, 1'b0, 32'h0,   32'h0,        4'h0, 32'h12345678, 1'b0);
`else
    do_req(0, 1'b0, 32'h402, 32'h0, 4'h0, 32'h12345678, 1'b0);
`endif
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_zero_wait();
    test_reset_mid();
    test_err();
    repeat (4) @(negedge clk);
    n_vec++;
    if (sb.size() != 0 || sb0.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d/%0d responses outstanding, want 0/0", sb.size(), sb0.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the target side of the core's load/store path.
- Accepts one word request at a time over a req/busy/resp_valid handshake.
- Inserts a fixed number of wait states, then answers with a one-cycle response carrying read data or a write acknowledge.
- Replaces the zero-latency data memory when the core moves to a stalling memory interface.

Parameters:
- DEPTH, 256: number of 32-bit words stored; power of two, at least 4.
- WAIT_STATES, 2: idle cycles between request accept and response; 0 to 15.
- DATA_WIDTH, 32: word width; fixed at 32, present for consistency with other memories.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- nrst  input  1  reset; synchronous, active-low.
- req  input  1  request strobe; sampled only while busy=0.
- we  input  1  1=store, 0=load; captured with req.
- address  input  32  byte address; captured with req.
- write_data  input  32  store data; captured with req.
- be  input  4  byte enables for stores; bit i covers bits [8i+7:8i]; ignored for loads.
- busy  output  1  high while a request is in flight; low only in IDLE.
- resp_valid  output  1  single-cycle response pulse.
- read_data  output  32  load word during resp_valid; 0 otherwise and for stores.
- err  output  1  error flag, valid with resp_valid (see Optional Feature); 0 otherwise.

Behaviour:
- Reset (nrst=0 at a clock edge): state=IDLE, wait counter=0, busy=0, resp_valid=0, read_data=0, err=0. Memory array contents are not reset.
- FSM states:
  - IDLE: busy=0. If req=1, capture we/address/write_data/be, load counter=WAIT_STATES, go to WAIT; if WAIT_STATES=0, go directly to RESP.
  - WAIT: busy=1. Counter decrements each cycle. When counter==1, go to RESP.
  - RESP: busy=1, resp_valid=1 for exactly one cycle, then IDLE.
- Latency: req accepted in cycle 0; resp_valid high in cycle 1+WAIT_STATES; busy low again in cycle 2+WAIT_STATES. Throughput: one request per WAIT_STATES+2 cycles.
- No back-to-back accept: req during the RESP cycle is ignored. The requester must hold req until it sees busy=0 for the cycle it wants accepted.
- Word index = captured address[log2(DEPTH)+1:2].
- Loads: read_data driven from the registered array read in the RESP cycle.
- Stores: array updated at the clock edge entering RESP, byte lanes per be only. be=4'b0000 still completes with resp_valid and changes nothing.
- A load following a store to the same word returns the new data.
- Reset during WAIT: request is discarded; no store commits; no response is issued.
- Reset during the RESP cycle: the store has already committed; resp_valid drops on the next cycle.
- Inputs are don't-care while busy=1.

Optional Feature:
- Macro DMEM_RESPONDER_ERR_CHECK_EN.
- Defined: err=1 with resp_valid when captured address[1:0]!=0 or address >= DEPTH*4. An erroring store does not modify the array; an erroring load returns read_data=0. Latency is unchanged.
- Undefined: err is tied 0; address[1:0] is ignored and the index wraps modulo DEPTH.

Decomposition:
- Shared package dmem_pkg holds:
  - state enum {IDLE, WAIT, RESP}
  - WORD_BYTES=4
  - BYTE_OFFSET_BITS=2
  - function for byte-lane merge of write_data into an old word under be
- One natural sub-module, dmem_sram_1rw: DEPTH x 32 single-port array with per-byte write enables and registered read. The responder holds the FSM, capture registers, counter and error logic.

Test Plan:
- Reset then idle: WAIT_STATES=2, hold nrst=0 two cycles -> busy=0, resp_valid=0, read_data=0, err=0; no resp_valid for 10 idle cycles.
- Store then load: store address 0x10, write_data 0xDEADBEEF, be=4'hF at cycle 0 -> resp_valid in cycle 3 and busy low in cycle 4; then load 0x10 -> read_data=0xDEADBEEF exactly 3 cycles after accept.
- Byte lanes: word 0x20 holds 0x11223344; store 0xAABBCCDD with be=4'b0101 -> subsequent load returns 0x11BB33DD. Store with be=0 leaves 0x11BB33DD.
- Zero wait states and busy gating: WAIT_STATES=0, req held high continuously -> resp_valid every 2nd cycle; a req during RESP is not accepted.
- Reset mid-operation: store to 0x30 (old value 0x0), nrst=0 in cycle 1 (WAIT) -> no resp_valid; a later load of 0x30 returns 0x00000000.
- Error check with DMEM_RESPONDER_ERR_CHECK_EN, DEPTH=256: load 0x402 -> err=1, read_data=0; store to 0x400 -> err=1 and word 0 is unchanged. Without the macro, load 0x402 returns word 0 with err=0.
